// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// FSM state encodings plus a sign-magnitude helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int ABS_W = 64;

    // Magnitude of a zero-extended WIDTH-bit value whose sign is passed in;
    // the caller truncates the result back to WIDTH bits.
    function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] v,
                                                  input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration over {acc, q}: radix-2 shift-add for multiply, or one
// restoring-subtract quotient bit for divide.
module muldiv_step #(
    parameter int WIDTH = 16
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        acc_next = '0;
        q_next   = '0;
        sum      = {1'b0, acc} + {1'b0, m};
        addend   = q[0] ? sum : {1'b0, acc};
        shifted  = {acc, q[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, m};
        if (div_mode) begin
            // No borrow means the shifted partial remainder covers the divisor.
            if (!diff[WIDTH+1]) begin
                acc_next = WIDTH'(diff);
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = WIDTH'(shifted);
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {acc_next, q_next} = {addend, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/MULU/DIV/DIVU unit with start/busy/done handshake, flush and
// global enable; results and flags are registered on DONE entry.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zf,
    output logic             nf,
    output logic             cf,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    op_e              op_q;
    logic             sa_q, sb_q, ovf_q;
    logic [WIDTH-1:0] m_q, q_q, acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             signed_in, start_ok, div_zero_in, calc_last;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] acc_step, q_step;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_lo, fix_hi;
    logic               fix_cf;

    assign signed_in   = op[0];
    assign start_ok    = start && (state_q == S_IDLE || state_q == S_DONE);
    assign div_zero_in = op[1] && (b == '0);
    assign calc_last   = (cnt_q == CNT_W'(WIDTH - 1));
    assign a_mag = signed_in ? WIDTH'(abs_val(ABS_W'(a), a[WIDTH-1])) : a;
    assign b_mag = signed_in ? WIDTH'(abs_val(ABS_W'(b), b[WIDTH-1])) : b;

    assign busy = (state_q == S_CALC) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (op_q[1]),
        .acc      (acc_q),
        .q        (q_q),
        .m        (m_q),
        .acc_next (acc_step),
        .q_next   (q_step)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) state_d = div_zero_in ? S_DONE : S_CALC;
            S_CALC: if (calc_last) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (start) state_d = div_zero_in ? S_DONE : S_CALC;
                    else       state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)       state_q <= S_IDLE;
        else if (flush)   state_q <= S_IDLE;
        else if (enable)  state_q <= state_d;
    end

    // Sign fix-up of the unsigned magnitudes; a divide remainder follows the dividend.
    always_comb begin
        prod   = {acc_q, q_q};
        fix_lo = '0;
        fix_hi = '0;
        fix_cf = 1'b0;
        if (op_q[1]) begin
            fix_lo = (sa_q ^ sb_q) ? -q_q : q_q;
            fix_hi = sa_q ? -acc_q : acc_q;
            fix_cf = ovf_q;
        end else begin
            if (sa_q ^ sb_q) prod = -prod;
            fix_lo = prod[WIDTH-1:0];
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_cf = (op_q == OP_MULU) ? (fix_hi != '0)
                                       : (fix_hi != {WIDTH{fix_lo[WIDTH-1]}});
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q      <= OP_MULU;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            ovf_q     <= 1'b0;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_lo <= '0;
            result_hi <= '0;
            zf        <= 1'b0;
            nf        <= 1'b0;
            cf        <= 1'b0;
            dz        <= 1'b0;
        end else if (!flush && enable) begin
            if (start_ok) begin
                op_q  <= op_e'(op);
                sa_q  <= signed_in & a[WIDTH-1];
                sb_q  <= signed_in & b[WIDTH-1];
                ovf_q <= (op == OP_DIV) && (a == {1'b1, {(WIDTH-1){1'b0}}})
                                        && (b == '1);
                m_q   <= b_mag;
                q_q   <= a_mag;
                acc_q <= '0;
                cnt_q <= '0;
                if (div_zero_in) begin
                    result_lo <= '1;
                    result_hi <= a;
                    zf        <= 1'b0;
                    nf        <= 1'b1;
                    cf        <= 1'b0;
                    dz        <= 1'b1;
                end
            end else if (state_q == S_CALC) begin
                acc_q <= acc_step;
                q_q   <= q_step;
                cnt_q <= cnt_q + 1'b1;
            end else if (state_q == S_FIX) begin
                result_lo <= fix_lo;
                result_hi <= fix_hi;
                zf        <= (fix_lo == '0);
                nf        <= fix_lo[WIDTH-1];
                cf        <= fix_cf;
                dz        <= 1'b0;
            end
        end
    end

endmodule
